// File: rtl/pixel_out_serializer_pkg.sv
`default_nettype none
// ============================================================================
// rast_pkg: shared rasterizer widths, lane counts and the parallel pixel word
// Revision: 1.0
// ============================================================================
package rast_pkg;
   localparam int XW_DEF   = 10;
   localparam int YW_DEF   = 8;
   localparam int CW_DEF   = 16;
   localparam int SER_DEF  = 2;
   localparam int FIFO_DEF = 4;

   localparam int X_LANES = XW_DEF / SER_DEF;
   localparam int Y_LANES = YW_DEF / SER_DEF;
   localparam int C_LANES = CW_DEF / SER_DEF;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;

   typedef struct packed {
      logic              last;
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
      logic [CW_DEF-1:0] color;
   } pixel_word_t;

   function automatic int lane_count(input int width, input int beats);
      return width / beats;
   endfunction
endpackage
`default_nettype wire

// File: rtl/pixel_out_serializer_if.sv
`default_nettype none
// ============================================================================
// pixel_out_serializer_if: pixel word handshake plus serialized lane outputs
// Revision: 1.0
// ============================================================================
interface pixel_out_serializer_if
   import rast_pkg::*;
#(
   parameter int XW         = XW_DEF,
   parameter int YW         = YW_DEF,
   parameter int CW         = CW_DEF,
   parameter int SER_CYCLES = SER_DEF
);
   logic                     in_valid;
   logic                     in_ready;
   logic [XW-1:0]            in_x;
   logic [YW-1:0]            in_y;
   logic [CW-1:0]            in_color;
   logic                     in_last;
   logic                     out_hold;
   logic [XW/SER_CYCLES-1:0] px;
   logic [YW/SER_CYCLES-1:0] py;
   logic [CW/SER_CYCLES-1:0] pc;
   logic                     valid;
   logic                     done;
   logic                     busy;

   modport master (
      output in_valid, in_x, in_y, in_color, in_last, out_hold,
      input  in_ready, px, py, pc, valid, done, busy
   );

   modport slave (
      input  in_valid, in_x, in_y, in_color, in_last, out_hold,
      output in_ready, px, py, pc, valid, done, busy
   );
endinterface
`default_nettype wire

// File: rtl/pixel_out_serializer_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo: single-clock FIFO, power-of-two depth, occupancy count output
// Revision: 1.0
// ============================================================================
module sync_fifo
   import rast_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = FIFO_DEF
) (
   input  wire logic                     clk_i,
   input  wire logic                     rst_i,
   input  wire logic                     push_i,
   input  wire logic [WIDTH-1:0]         wdata_i,
   input  wire logic                     pop_i,
   output logic      [WIDTH-1:0]         rdata_o,
   output logic      [$clog2(DEPTH):0]   count_o,
   output logic                          full_o,
   output logic                          empty_o
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNTW-1:0]  count_q;
   logic             w_do_push;
   logic             w_do_pop;

   // A full FIFO refuses a push even when a pop lands on the same edge.
   assign full_o    = (count_q == CNTW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && !empty_o;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_ff @(posedge clk_i) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + CNTW'(1);
            2'b01:   count_q <= count_q - CNTW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/pixel_out_serializer.sv
`default_nettype none
// ============================================================================
// pixel_out_serializer: buffers pixel words and shifts them out over lanes
// Revision: 1.0
// ============================================================================
module pixel_out_serializer
   import rast_pkg::*;
#(
   parameter int XW         = XW_DEF,
   parameter int YW         = YW_DEF,
   parameter int CW         = CW_DEF,
   parameter int SER_CYCLES = SER_DEF,
   parameter int FIFO_DEPTH = FIFO_DEF
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   pixel_out_serializer_if.slave pix_if
);
   localparam int XL   = lane_count(XW, SER_CYCLES);
   localparam int YL   = lane_count(YW, SER_CYCLES);
   localparam int CL   = lane_count(CW, SER_CYCLES);
   localparam int WW   = 1 + XW + YW + CW;
   localparam int BW   = (SER_CYCLES > 1) ? $clog2(SER_CYCLES) : 1;
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(SER_CYCLES - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   if ((XW % SER_CYCLES) != 0 || (YW % SER_CYCLES) != 0 || (CW % SER_CYCLES) != 0) begin : g_bad_width
      $error("pixel_out_serializer: XW, YW and CW must be multiples of SER_CYCLES");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pixel_out_serializer: FIFO_DEPTH must be a power of two, at least 2");
   end

   logic [0:0]      state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [XW-1:0]   sx_q, sx_d;
   logic [YW-1:0]   sy_q, sy_d;
   logic [CW-1:0]   sc_q, sc_d;
   logic            last_q, last_d;
   logic            done_q, done_d;

   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [WW-1:0]   w_rdata;
   logic [CNTW-1:0] w_count;
   logic            w_start;
   logic            w_shift;

   assign pix_if.in_ready = !rst_i && !w_full;

   sync_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (pix_if.in_valid && pix_if.in_ready),
      .wdata_i ({pix_if.in_last, pix_if.in_x, pix_if.in_y, pix_if.in_color}),
      .pop_i   (w_pop),
      .rdata_o (w_rdata),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign w_start = !w_empty && !pix_if.out_hold;

   // Each field shifts right once per beat, so lane k always reads bit k*S.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      sc_d    = sc_q;
      last_d  = last_q;
      done_d  = 1'b0;
      w_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_start) begin
               w_pop   = 1'b1;
               state_d = ST_SHIFT;
               beat_d  = '0;
               {last_d, sx_d, sy_d, sc_d} = w_rdata;
            end
         end
         ST_SHIFT: begin
            if (beat_q == LAST_BEAT) begin
               done_d = last_q;
               beat_d = '0;
               if (w_start) begin
                  w_pop = 1'b1;
                  {last_d, sx_d, sy_d, sc_d} = w_rdata;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               beat_d = beat_q + BW'(1);
               sx_d   = sx_q >> 1;
               sy_d   = sy_q >> 1;
               sc_d   = sc_q >> 1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         sc_q    <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         sc_q    <= sc_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign w_shift = (state_q == ST_SHIFT);

   logic [XL-1:0] w_px;
   logic [YL-1:0] w_py;
   logic [CL-1:0] w_pc;

   for (genvar k = 0; k < XL; k++) begin : g_px
      assign w_px[k] = w_shift && sx_q[k*SER_CYCLES];
   end
   for (genvar k = 0; k < YL; k++) begin : g_py
      assign w_py[k] = w_shift && sy_q[k*SER_CYCLES];
   end
   for (genvar k = 0; k < CL; k++) begin : g_pc
      assign w_pc[k] = w_shift && sc_q[k*SER_CYCLES];
   end

   assign pix_if.px    = w_px;
   assign pix_if.py    = w_py;
   assign pix_if.pc    = w_pc;
   assign pix_if.valid = w_shift && (beat_q == '0);
   assign pix_if.done  = done_q;
   assign pix_if.busy  = (w_count != '0) || w_shift;
endmodule
`default_nettype wire

// File: tb/tb_pixel_out_serializer.sv
`default_nettype none
// ============================================================================
// tb_pixel_out_serializer: scoreboard bench for S=2 (default), S=1 and S=4
// Revision: 1.0
// ============================================================================
module tb_pixel_out_serializer;
   import rast_pkg::*;

   localparam int S0  = 2;
   localparam int XL0 = 5;
   localparam int YL0 = 4;
   localparam int CL0 = 8;

   typedef struct packed {
      logic        last;
      logic [11:0] x;
      logic [7:0]  y;
      logic [15:0] c;
   } aword_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pixel_word_t q0[$];
   aword_t      q1[$];
   aword_t      q4[$];

   always #5 clk = ~clk;

   pixel_out_serializer_if #(.XW(10), .YW(8), .CW(16), .SER_CYCLES(2)) if0 ();
   pixel_out_serializer_if #(.XW(12), .YW(8), .CW(16), .SER_CYCLES(1)) if1 ();
   pixel_out_serializer_if #(.XW(12), .YW(8), .CW(16), .SER_CYCLES(4)) if4 ();

   pixel_out_serializer #(.XW(10), .YW(8), .CW(16), .SER_CYCLES(2), .FIFO_DEPTH(4)) u_dut0 (
      .clk_i (clk), .rst_i (rst), .pix_if (if0));
   pixel_out_serializer #(.XW(12), .YW(8), .CW(16), .SER_CYCLES(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk_i (clk), .rst_i (rst), .pix_if (if1));
   pixel_out_serializer #(.XW(12), .YW(8), .CW(16), .SER_CYCLES(4), .FIFO_DEPTH(4)) u_dut4 (
      .clk_i (clk), .rst_i (rst), .pix_if (if4));

   task automatic tick;
      @(negedge clk);
   endtask

   // Reference lane picker: lane k on beat j carries bit k*s+j.
   function automatic logic [15:0] lanes_of(input logic [15:0] v, input int nl, input int s, input int j);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < nl; k++) r[k] = v[k*s+j];
      return r;
   endfunction

   function automatic pixel_word_t rand_word0(input logic last);
      pixel_word_t w;
      w.x = 10'($urandom); w.y = 8'($urandom); w.color = 16'($urandom); w.last = last;
      return w;
   endfunction

   task automatic push0(input pixel_word_t w, output bit acc);
      acc = 1'b0;
      if0.in_x = w.x; if0.in_y = w.y; if0.in_color = w.color; if0.in_last = w.last;
      if0.in_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         if (if0.in_ready === 1'b1) begin
            q0.push_back(w);
            acc = 1'b1;
            tick();
            break;
         end
         tick();
      end
   endtask

   // Deserializes one S=2 word starting at the current negedge.
   task automatic grab0(output pixel_word_t w, output int gap, output bit done_after, output bit ok);
      bit bad;
      w = '0; gap = 0; done_after = 1'b0; ok = 1'b0; bad = 1'b0;
      while (if0.valid !== 1'b1 && gap < 50) begin
         tick();
         gap++;
      end
      if (if0.valid !== 1'b1) return;
      for (int j = 0; j < S0; j++) begin
         if (j > 0 && if0.valid !== 1'b0) bad = 1'b1;
         for (int k = 0; k < XL0; k++) w.x[k*S0+j] = if0.px[k];
         for (int k = 0; k < YL0; k++) w.y[k*S0+j] = if0.py[k];
         for (int k = 0; k < CL0; k++) w.color[k*S0+j] = if0.pc[k];
         tick();
      end
      done_after = if0.done;
      ok = !bad;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", if0.in_ready); end
      checks++;
      if ({if0.valid, if0.done, if0.busy, if0.px, if0.py, if0.pc} !== '0)
         begin errors++; $display("FAIL reset_outs got v=%b d=%b b=%b px=%h exp all 0", if0.valid, if0.done, if0.busy, if0.px); end
      rst = 1'b0;
      #1;
      checks++;
      if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", if0.in_ready); end
      tick();
   endtask

   task automatic test_single;
      logic [15:0] e;
      if0.in_x = 10'h2A5; if0.in_y = 8'h5C; if0.in_color = 16'hF801; if0.in_last = 1'b0;
      if0.in_valid = 1'b1;
      checks++;
      if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", if0.in_ready); end
      tick();
      if0.in_valid = 1'b0;
      checks++;
      if (if0.valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", if0.valid); end
      tick();
      checks++;
      if (if0.valid !== 1'b1 || if0.px !== 5'b00011)
         begin errors++; $display("FAIL single_beat0_px valid=%b px=%b exp valid=1 px=00011", if0.valid, if0.px); end
      e = lanes_of(16'h005C, YL0, S0, 0);
      checks++;
      if ({12'b0, if0.py} !== e) begin errors++; $display("FAIL single_beat0_py got=%h exp=%h", if0.py, e); end
      e = lanes_of(16'hF801, CL0, S0, 0);
      checks++;
      if ({8'b0, if0.pc} !== e) begin errors++; $display("FAIL single_beat0_pc got=%h exp=%h", if0.pc, e); end
      tick();
      checks++;
      if (if0.valid !== 1'b0 || if0.px !== 5'b11100)
         begin errors++; $display("FAIL single_beat1_px valid=%b px=%b exp valid=0 px=11100", if0.valid, if0.px); end
      e = lanes_of(16'h005C, YL0, S0, 1);
      checks++;
      if ({12'b0, if0.py} !== e) begin errors++; $display("FAIL single_beat1_py got=%h exp=%h", if0.py, e); end
      e = lanes_of(16'hF801, CL0, S0, 1);
      checks++;
      if ({8'b0, if0.pc} !== e) begin errors++; $display("FAIL single_beat1_pc got=%h exp=%h", if0.pc, e); end
      tick();
      checks++;
      if ({if0.valid, if0.done, if0.busy} !== 3'b000 || if0.px !== 5'b0)
         begin errors++; $display("FAIL single_idle v=%b d=%b b=%b px=%b exp 0", if0.valid, if0.done, if0.busy, if0.px); end
   endtask

   task automatic test_back_to_back;
      fork
         begin
            bit acc;
            for (int i = 0; i < 4; i++) begin
               push0(rand_word0(i == 3), acc);
               checks++;
               if (!acc) begin errors++; $display("FAIL b2b_push%0d got=timeout exp=accept", i); end
            end
            if0.in_valid = 1'b0;
         end
         begin
            pixel_word_t w, e;
            int gap;
            bit dn, ok;
            for (int i = 0; i < 4; i++) begin
               grab0(w, gap, dn, ok);
               checks++;
               if (!ok || q0.size() == 0) begin
                  errors++; $display("FAIL b2b_word%0d got=no_word exp=word", i);
               end else begin
                  e = q0.pop_front();
                  checks++;
                  if ({w.x, w.y, w.color} !== {e.x, e.y, e.color})
                     begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, {w.x, w.y, w.color}, {e.x, e.y, e.color}); end
                  checks++;
                  if (dn !== e.last) begin errors++; $display("FAIL b2b_done%0d got=%b exp=%b", i, dn, e.last); end
               end
               if (i > 0) begin
                  checks++;
                  if (gap != 0) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=0", i, gap); end
               end
            end
            tick();
            checks++;
            if (if0.done !== 1'b0) begin errors++; $display("FAIL b2b_done_extra got=%b exp=0", if0.done); end
         end
      join
   endtask

   task automatic test_hold_fill;
      pixel_word_t w, e;
      int gap;
      bit dn, ok, acc;
      if0.out_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push0(rand_word0(1'b0), acc);
         checks++;
         if (!acc) begin errors++; $display("FAIL fill_push%0d got=timeout exp=accept", i); end
      end
      w = rand_word0(1'b0);
      if0.in_x = w.x; if0.in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({if0.in_ready, if0.valid, if0.busy} !== 3'b001)
            begin errors++; $display("FAIL fill_full rdy=%b v=%b b=%b exp rdy=0 v=0 b=1", if0.in_ready, if0.valid, if0.busy); end
         tick();
      end
      if0.in_valid = 1'b0;
      if0.out_hold = 1'b0;
      tick();
      checks++;
      if (if0.in_ready !== 1'b1 || if0.valid !== 1'b1)
         begin errors++; $display("FAIL fill_release rdy=%b v=%b exp rdy=1 v=1", if0.in_ready, if0.valid); end
      for (int i = 0; i < 4; i++) begin
         grab0(w, gap, dn, ok);
         checks++;
         if (!ok || q0.size() == 0) begin
            errors++; $display("FAIL fill_word%0d got=no_word exp=word", i);
         end else begin
            e = q0.pop_front();
            checks++;
            if ({w.x, w.y, w.color, dn} !== {e.x, e.y, e.color, 1'b0})
               begin errors++; $display("FAIL fill_data%0d got=%h exp=%h", i, {w.x, w.y, w.color, dn}, {e.x, e.y, e.color, 1'b0}); end
         end
      end
   endtask

   task automatic test_hold_mid;
      pixel_word_t w, e;
      int gap;
      bit dn, ok, acc;
      for (int i = 0; i < 2; i++) begin
         push0(rand_word0(1'b0), acc);
         checks++;
         if (!acc) begin errors++; $display("FAIL hold_push%0d got=timeout exp=accept", i); end
      end
      if0.in_valid = 1'b0;
      checks++;
      if (if0.valid !== 1'b1) begin errors++; $display("FAIL hold_beat0 got=%b exp=1", if0.valid); end
      if0.out_hold = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (i == 1) begin
            for (int c = 0; c < 2; c++) begin
               checks++;
               if (if0.valid !== 1'b0 || if0.busy !== 1'b1)
                  begin errors++; $display("FAIL hold_stalled v=%b b=%b exp v=0 b=1", if0.valid, if0.busy); end
               tick();
            end
            if0.out_hold = 1'b0;
            tick();
            checks++;
            if (if0.valid !== 1'b1) begin errors++; $display("FAIL hold_restart got=%b exp=1", if0.valid); end
         end
         grab0(w, gap, dn, ok);
         checks++;
         if (!ok || q0.size() == 0) begin
            errors++; $display("FAIL hold_word%0d got=no_word exp=word", i);
         end else begin
            e = q0.pop_front();
            checks++;
            if ({w.x, w.y, w.color} !== {e.x, e.y, e.color})
               begin errors++; $display("FAIL hold_data%0d got=%h exp=%h", i, {w.x, w.y, w.color}, {e.x, e.y, e.color}); end
         end
      end
   endtask

   task automatic test_reset_mid;
      pixel_word_t w, e;
      int gap;
      bit dn, ok, acc;
      if0.out_hold = 1'b1;
      for (int i = 0; i < 4; i++) push0(rand_word0(i == 3), acc);
      if0.in_valid = 1'b0;
      if0.out_hold = 1'b0;
      tick();
      checks++;
      if (if0.valid !== 1'b1) begin errors++; $display("FAIL rstmid_beat0 got=%b exp=1", if0.valid); end
      rst = 1'b1;
      tick();
      checks++;
      if ({if0.in_ready, if0.valid, if0.done, if0.busy, if0.px, if0.py, if0.pc} !== '0)
         begin errors++; $display("FAIL rstmid_outs rdy=%b v=%b d=%b b=%b px=%h exp all 0", if0.in_ready, if0.valid, if0.done, if0.busy, if0.px); end
      rst = 1'b0;
      q0.delete();
      tick();
      checks++;
      if ({if0.valid, if0.done, if0.busy} !== 3'b000)
         begin errors++; $display("FAIL rstmid_after v=%b d=%b b=%b exp 000", if0.valid, if0.done, if0.busy); end
      push0(rand_word0(1'b1), acc);
      if0.in_valid = 1'b0;
      grab0(w, gap, dn, ok);
      checks++;
      if (!ok || !acc || q0.size() == 0) begin
         errors++; $display("FAIL rstmid_fresh got=no_word exp=word");
      end else begin
         e = q0.pop_front();
         checks++;
         if ({w.x, w.y, w.color, dn} !== {e.x, e.y, e.color, 1'b1})
            begin errors++; $display("FAIL rstmid_data got=%h exp=%h", {w.x, w.y, w.color, dn}, {e.x, e.y, e.color, 1'b1}); end
      end
   endtask

   task automatic test_s1;
      int nv = 0, nd = 0, nlast = 0;
      fork
         begin
            aword_t w;
            bit acc;
            for (int i = 0; i < 12; i++) begin
               w = aword_t'({$urandom, $urandom});
               nlast += int'(w.last);
               if1.in_x = w.x; if1.in_y = w.y; if1.in_color = w.c; if1.in_last = w.last;
               if1.in_valid = 1'b1;
               acc = 1'b0;
               for (int n = 0; n < 50 && !acc; n++) begin
                  if (if1.in_ready === 1'b1) begin q1.push_back(w); acc = 1'b1; end
                  tick();
               end
               if1.in_valid = 1'b0;
               checks++;
               if (!acc) begin errors++; $display("FAIL s1_push%0d got=timeout exp=accept", i); end
               repeat ($urandom_range(0, 2)) tick();
            end
         end
         begin
            aword_t e;
            for (int i = 0; i < 12; i++) begin
               int t = 0;
               while (if1.valid !== 1'b1 && t < 60) begin tick(); t++; end
               checks++;
               if (if1.valid !== 1'b1 || q1.size() == 0) begin
                  errors++; $display("FAIL s1_word%0d got=timeout exp=valid", i);
                  break;
               end
               nv++;
               e = q1.pop_front();
               checks++;
               if ({if1.px, if1.py, if1.pc} !== {e.x, e.y, e.c})
                  begin errors++; $display("FAIL s1_data%0d got=%h exp=%h", i, {if1.px, if1.py, if1.pc}, {e.x, e.y, e.c}); end
               tick();
               if (if1.done === 1'b1) nd++;
               checks++;
               if (if1.done !== e.last) begin errors++; $display("FAIL s1_done%0d got=%b exp=%b", i, if1.done, e.last); end
            end
         end
      join
      checks++;
      if (nv != 12 || nd != nlast) begin errors++; $display("FAIL s1_counts got valid=%0d done=%0d exp valid=12 done=%0d", nv, nd, nlast); end
   endtask

   task automatic test_s4;
      int nv = 0, nd = 0, nlast = 0;
      fork
         begin
            aword_t w;
            bit acc;
            for (int i = 0; i < 12; i++) begin
               w = aword_t'({$urandom, $urandom});
               nlast += int'(w.last);
               if4.in_x = w.x; if4.in_y = w.y; if4.in_color = w.c; if4.in_last = w.last;
               if4.in_valid = 1'b1;
               acc = 1'b0;
               for (int n = 0; n < 80 && !acc; n++) begin
                  if (if4.in_ready === 1'b1) begin q4.push_back(w); acc = 1'b1; end
                  tick();
               end
               if4.in_valid = 1'b0;
               checks++;
               if (!acc) begin errors++; $display("FAIL s4_push%0d got=timeout exp=accept", i); end
               repeat ($urandom_range(0, 6)) tick();
            end
         end
         begin
            aword_t e;
            logic [11:0] rx;
            logic [7:0]  ry;
            logic [15:0] rc;
            bit bad;
            for (int i = 0; i < 12; i++) begin
               int t = 0;
               while (if4.valid !== 1'b1 && t < 80) begin tick(); t++; end
               checks++;
               if (if4.valid !== 1'b1 || q4.size() == 0) begin
                  errors++; $display("FAIL s4_word%0d got=timeout exp=valid", i);
                  break;
               end
               nv++;
               bad = 1'b0;
               for (int j = 0; j < 4; j++) begin
                  if (j > 0 && if4.valid !== 1'b0) bad = 1'b1;
                  for (int k = 0; k < 3; k++) rx[k*4+j] = if4.px[k];
                  for (int k = 0; k < 2; k++) ry[k*4+j] = if4.py[k];
                  for (int k = 0; k < 4; k++) rc[k*4+j] = if4.pc[k];
                  tick();
               end
               e = q4.pop_front();
               checks++;
               if ({rx, ry, rc, bad} !== {e.x, e.y, e.c, 1'b0})
                  begin errors++; $display("FAIL s4_data%0d got=%h exp=%h", i, {rx, ry, rc, bad}, {e.x, e.y, e.c, 1'b0}); end
               if (if4.done === 1'b1) nd++;
               checks++;
               if (if4.done !== e.last) begin errors++; $display("FAIL s4_done%0d got=%b exp=%b", i, if4.done, e.last); end
            end
         end
      join
      checks++;
      if (nv != 12 || nd != nlast) begin errors++; $display("FAIL s4_counts got valid=%0d done=%0d exp valid=12 done=%0d", nv, nd, nlast); end
   endtask

   initial begin
      if0.in_valid = 1'b0; if0.in_x = '0; if0.in_y = '0; if0.in_color = '0; if0.in_last = 1'b0; if0.out_hold = 1'b0;
      if1.in_valid = 1'b0; if1.in_x = '0; if1.in_y = '0; if1.in_color = '0; if1.in_last = 1'b0; if1.out_hold = 1'b0;
      if4.in_valid = 1'b0; if4.in_x = '0; if4.in_y = '0; if4.in_color = '0; if4.in_last = 1'b0; if4.out_hold = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_fill();
      test_hold_mid();
      test_reset_mid();
      test_s1();
      test_s4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
